fifo_controller: RTL

Synchronous First-In First-Out queue controller, the queue counterpart of the stack controller in the same data/controllers family. Writes go in at the tail and reads come out of the head, the opposite end from the write side. It drives an external dual-port memory with an asynchronous (combinational) read port. Read data is first-word-fall-through: the head entry is always presented on read_data while the queue is not empty.

---
 rtl/wrapping_pointer.sv | 46 ++++
 rtl/fifo_controller.sv | 71 +++++++
 2 files changed

// File: rtl/wrapping_pointer.sv
// Queue pointer {lap, address}. The address wraps from DEPTH-1 back to 0, and the lap
// bit toggles on each wrap so that full and empty can be told apart.
module wrapping_pointer #(
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  increment,
  output logic [DEPTH_LOG2-1:0] address,
  output logic                  lap
);

  localparam logic [DEPTH_LOG2-1:0] LAST_ADDRESS = DEPTH_LOG2'(DEPTH - 1);

  logic [DEPTH_LOG2-1:0] address_q, address_d;
  logic                  lap_q, lap_d;

  // Wrap on LAST_ADDRESS rather than on overflow, so a DEPTH that is not a power of two works.
  always_comb begin
    address_d = address_q;
    lap_d     = lap_q;
    if (increment) begin
      if (address_q == LAST_ADDRESS) begin
        address_d = '0;
        lap_d     = ~lap_q;
      end else begin
        address_d = address_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      address_q <= '0;
      lap_q     <= 1'b0;
    end else begin
      address_q <= address_d;
      lap_q     <= lap_d;
    end
  end

  assign address = address_q;
  assign lap     = lap_q;

endmodule

// File: rtl/fifo_controller.sv
// First-word-fall-through FIFO controller that drives an external dual-port memory with a
// combinational read port. Only the two pointers are state; all status is derived from them.
module fifo_controller #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  resetn,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  input  logic                  write_enable,
  input  logic [WIDTH-1:0]      write_data,
  input  logic                  read_enable,
  output logic [WIDTH-1:0]      read_data,
  output logic                  memory_write_enable,
  output logic [DEPTH_LOG2-1:0] memory_write_address,
  output logic [WIDTH-1:0]      memory_write_data,
  output logic                  memory_read_enable,
  output logic [DEPTH_LOG2-1:0] memory_read_address,
  input  logic [WIDTH-1:0]      memory_read_data
);

  localparam logic [DEPTH_LOG2:0] DEPTH_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DEPTH_LOG2-1:0] write_address, read_address;
  logic                  write_lap, read_lap;
  logic                  push_accept, pop_accept, addresses_equal;

  wrapping_pointer #(.DEPTH(DEPTH), .DEPTH_LOG2(DEPTH_LOG2)) u_write_pointer (
    .clock     (clock),
    .resetn    (resetn),
    .increment (push_accept),
    .address   (write_address),
    .lap       (write_lap)
  );

  wrapping_pointer #(.DEPTH(DEPTH), .DEPTH_LOG2(DEPTH_LOG2)) u_read_pointer (
    .clock     (clock),
    .resetn    (resetn),
    .increment (pop_accept),
    .address   (read_address),
    .lap       (read_lap)
  );

  assign addresses_equal = (write_address == read_address);
  assign empty           = addresses_equal && (write_lap == read_lap);
  assign full            = addresses_equal && (write_lap != read_lap);

  // When the laps differ, the writer has wrapped once more than the reader.
  always_comb begin
    if (write_lap == read_lap) begin
      level = {1'b0, write_address} - {1'b0, read_address};
    end else begin
      level = DEPTH_COUNT - {1'b0, read_address} + {1'b0, write_address};
    end
  end

  assign push_accept = write_enable && !full;
  assign pop_accept  = read_enable && !empty;

  assign memory_write_enable  = push_accept;
  assign memory_write_address = write_address;
  assign memory_write_data    = write_data;

  assign memory_read_enable  = !empty;
  assign memory_read_address = read_address;
  assign read_data           = memory_read_data;

endmodule
